// File: rtl/fub_pkg.sv
// Shared types and default geometry for the feature unpack buffer.
// Optional ReLU on emitted elements is enabled by defining FUB_RELU_EN.
package fub_pkg;

  typedef enum logic [1:0] {LOAD, READY, STREAM} state_e;

  localparam int DEF_WORD_W      = 32;
  localparam int DEF_ELEM_W      = 8;
  localparam int DEF_DEPTH_WORDS = 43;
  localparam int DEF_NUM_ELEMS   = 169;
  localparam int DEF_LANES       = 4;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int idx_width(input int num_elems, input int lanes);
    return $clog2(num_elems + lanes);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ELEMS_PER_WORD = DEF_WORD_W / DEF_ELEM_W;
  localparam int NUM_BEATS      = ceil_div(DEF_NUM_ELEMS, DEF_LANES);
  localparam int WR_PTR_W       = ptr_width(DEF_DEPTH_WORDS);
  localparam int ELEM_IDX_W     = idx_width(DEF_NUM_ELEMS, DEF_LANES);

endpackage

// File: rtl/fub_elem_select.sv
// Maps a flat element index onto its ELEM_W slice of a packed word (MSB-first),
// zero-padding indices past the map and optionally clamping negatives (FUB_RELU_EN).
module fub_elem_select
  import fub_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ELEM_W    = DEF_ELEM_W,
  parameter int NUM_ELEMS = DEF_NUM_ELEMS,
  parameter int IDX_W     = ELEM_IDX_W
) (
  input  logic [IDX_W-1:0]  elem_idx,
  input  logic [WORD_W-1:0] word,
  output logic [ELEM_W-1:0] elem
);

  localparam int EPW   = WORD_W / ELEM_W;
  localparam int SEL_W = ptr_width(EPW);

  logic [SEL_W-1:0]  sel;
  logic [WORD_W-1:0] shifted;
  logic [ELEM_W-1:0] raw;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    sel     = SEL_W'(elem_idx % IDX_W'(EPW));
    shifted = word << (sel * ELEM_W);
    raw     = shifted[WORD_W-1 -: ELEM_W];
    elem    = '0;
    if (elem_idx < IDX_W'(NUM_ELEMS)) begin
`ifdef FUB_RELU_EN
      elem = raw[ELEM_W-1] ? '0 : raw;
`else
      elem = raw;
`endif
    end
  end

endmodule

// File: rtl/feature_unpack_buffer.sv
// Loads a flattened feature map as packed words and streams it LANES elements per beat.
// Define FUB_RELU_EN to zero negative elements on the way out.
module feature_unpack_buffer
  import fub_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int ELEM_W      = DEF_ELEM_W,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int NUM_ELEMS   = DEF_NUM_ELEMS,
  parameter int LANES       = DEF_LANES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  output logic                      load_done,
  input  logic                      start,
  input  logic                      reload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ELEM_W-1:0]   out_data,
  output logic                      out_last
);

  localparam int EPW   = WORD_W / ELEM_W;
  localparam int IDX_W = idx_width(NUM_ELEMS, LANES);
  localparam int PTR_W = ptr_width(DEPTH_WORDS);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]          elem_idx_q, elem_idx_d;
  logic                      load_done_q, load_done_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [LANES*ELEM_W-1:0]   out_data_q, out_data_d;

  logic                      wr_en;
  logic [IDX_W-1:0]          beat_base;
  logic [LANES*ELEM_W-1:0]   beat_data;

  assign wr_en = (state_q == LOAD) && in_valid;

  // Index of the first element of the beat that would be registered at the next edge.
  assign beat_base = (state_q == STREAM) ? elem_idx_q + IDX_W'(LANES) : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0]  lane_idx;
    int unsigned       word_idx;
    logic [WORD_W-1:0] lane_word;

    assign lane_idx  = beat_base + IDX_W'(l);
    assign word_idx  = int'(lane_idx) / EPW;
    assign lane_word = (word_idx < DEPTH_WORDS) ? mem[PTR_W'(word_idx)] : '0;

    fub_elem_select #(
      .WORD_W   (WORD_W),
      .ELEM_W   (ELEM_W),
      .NUM_ELEMS(NUM_ELEMS),
      .IDX_W    (IDX_W)
    ) u_sel (
      .elem_idx(lane_idx),
      .word    (lane_word),
      .elem    (beat_data[(LANES-1-l)*ELEM_W +: ELEM_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    elem_idx_d  = elem_idx_q;
    load_done_d = load_done_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == PTR_W'(DEPTH_WORDS - 1)) begin
            state_d     = READY;
            load_done_d = 1'b1;
          end
        end
      end
      READY: begin
        if (reload) begin
          state_d     = LOAD;
          load_done_d = 1'b0;
          wr_ptr_d    = '0;
        end else if (start) begin
          state_d     = STREAM;
          elem_idx_d  = '0;
          out_valid_d = 1'b1;
          out_data_d  = beat_data;
          out_last_d  = (LANES >= NUM_ELEMS);
        end
      end
      STREAM: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = READY;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            elem_idx_d = beat_base;
            out_data_d = beat_data;
            out_last_d = (int'(beat_base) + LANES >= NUM_ELEMS);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; storage has no reset since a load always precedes a read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      elem_idx_q  <= '0;
      load_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      elem_idx_q  <= elem_idx_d;
      load_done_q <= load_done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign load_done = load_done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule
